// File: rtl/seg_pkg.sv
// Shared constants for the multiplexed seven-segment scanner.
// Segment patterns are active-high, bit7..bit1 = a..g, bit0 = dp (always 0 here;
// the decimal point is ORed in by the decoder).
package seg_pkg;

    localparam logic [7:0] SEG_0     = 8'b1111_1100;
    localparam logic [7:0] SEG_1     = 8'b0110_0000;
    localparam logic [7:0] SEG_2     = 8'b1101_1010;
    localparam logic [7:0] SEG_3     = 8'b1111_0010;
    localparam logic [7:0] SEG_4     = 8'b0110_0110;
    localparam logic [7:0] SEG_5     = 8'b1011_0110;
    localparam logic [7:0] SEG_6     = 8'b1011_1110;
    localparam logic [7:0] SEG_7     = 8'b1110_0000;
    localparam logic [7:0] SEG_8     = 8'b1111_1110;
    localparam logic [7:0] SEG_9     = 8'b1111_0110;
    localparam logic [7:0] SEG_MINUS = 8'b0000_0010;
    localparam logic [7:0] SEG_BLANK = 8'b0000_0000;

    localparam logic [3:0] CODE_MINUS = 4'hA;
    localparam logic [3:0] CODE_BLANK = 4'hF;

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Display-side bundle of the seven-segment scanner.
//   load       : single-cycle strobe capturing code_in / dp_in
//   code_in    : packed nibbles, nibble k = digit k, digit 0 rightmost
//   dp_in      : per-digit decimal point, 1 = lit
//   lz_en      : leading-zero suppression enable (sampled live)
//   ena        : one-hot digit enable, active-high
//   light      : segment pattern a..g,dp (bit7..bit0), active-high
//   frame_done : one-cycle pulse after each frame boundary
// master = register/CPU side, slave = scanner.
interface seg_scan_ctrl_if #(
    parameter int unsigned DIGITS = 8
) ();
    logic                  load;
    logic [4*DIGITS-1:0]   code_in;
    logic [DIGITS-1:0]     dp_in;
    logic                  lz_en;
    logic [DIGITS-1:0]     ena;
    logic [7:0]            light;
    logic                  frame_done;

    modport master (
        output load, code_in, dp_in, lz_en,
        input  ena, light, frame_done
    );

    modport slave (
        input  load, code_in, dp_in, lz_en,
        output ena, light, frame_done
    );
endinterface

// File: rtl/seg_decode.sv
// Combinational code-to-segment decoder.
//   code  : 4-bit digit code (0-9 digits, A minus, B-F blank)
//   dp    : decimal point, ORed into bit0 for every code
//   light : segment pattern a..g,dp
module seg_decode
    import seg_pkg::*;
(
    input  logic [3:0] code,
    input  logic       dp,
    output logic [7:0] light
);
    logic [7:0] glyph;

    always_comb begin
        glyph = SEG_BLANK;
        case (code)
            4'd0:       glyph = SEG_0;
            4'd1:       glyph = SEG_1;
            4'd2:       glyph = SEG_2;
            4'd3:       glyph = SEG_3;
            4'd4:       glyph = SEG_4;
            4'd5:       glyph = SEG_5;
            4'd6:       glyph = SEG_6;
            4'd7:       glyph = SEG_7;
            4'd8:       glyph = SEG_8;
            4'd9:       glyph = SEG_9;
            CODE_MINUS: glyph = SEG_MINUS;
            default:    glyph = SEG_BLANK;
        endcase
        light = glyph | {7'b0, dp};
    end
endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment display scanner.
// Drives DIGITS common-enable digits one slot at a time, DIV clocks per slot, with
// the first BLANK clocks of each slot dark to avoid ghosting. New data is staged in
// a shadow register and only committed at the frame boundary so a frame never tears.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : seg_scan_ctrl_if slave (load/code_in/dp_in/lz_en in; ena/light/frame_done out)
// All outputs are registered (one cycle after the state they describe).
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int unsigned DIGITS = 8,
    parameter int unsigned DIV    = 100000,
    parameter int unsigned BLANK  = 1000
) (
    input  logic            clk,
    input  logic            rst_n,
    seg_scan_ctrl_if.slave  bus
);
    localparam int unsigned CntW  = $clog2(DIV);
    localparam int unsigned SlotW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [SlotW-1:0]    slot_q, slot_d;
    logic [4*DIGITS-1:0] shadow_code_q, shadow_code_d;
    logic [DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
    logic                pending_q, pending_d;
    logic [4*DIGITS-1:0] active_code_q, active_code_d;
    logic [DIGITS-1:0]   active_dp_q, active_dp_d;
    logic [DIGITS-1:0]   ena_q, ena_d;
    logic [7:0]          light_q, light_d;
    logic                frame_done_q;

    logic                slot_end;
    logic                boundary;
    logic                lit;
    logic [DIGITS-1:0]   supp;
    logic                seen_nz;
    logic [3:0]          cur_code;
    logic                cur_dp;
    logic [7:0]          dec_light;

    assign slot_end = (cnt_q == CntW'(DIV - 1));
    assign boundary = slot_end && (slot_q == SlotW'(DIGITS - 1));
    assign lit      = (cnt_q >= CntW'(BLANK));

    // Prescaler, slot counter and shadow/active data path.
    always_comb begin
        cnt_d         = cnt_q + 1'b1;
        slot_d        = slot_q;
        shadow_code_d = shadow_code_q;
        shadow_dp_d   = shadow_dp_q;
        pending_d     = pending_q;
        active_code_d = active_code_q;
        active_dp_d   = active_dp_q;

        if (slot_end) begin
            cnt_d  = '0;
            slot_d = (slot_q == SlotW'(DIGITS - 1)) ? '0 : slot_q + 1'b1;
        end

        if (bus.load) begin
            shadow_code_d = bus.code_in;
            shadow_dp_d   = bus.dp_in;
            pending_d     = 1'b1;
        end

        // A load coinciding with the boundary bypasses the shadow entirely.
        if (boundary) begin
            if (bus.load) begin
                active_code_d = bus.code_in;
                active_dp_d   = bus.dp_in;
                pending_d     = 1'b0;
            end else if (pending_q) begin
                active_code_d = shadow_code_q;
                active_dp_d   = shadow_dp_q;
                pending_d     = 1'b0;
            end
        end
    end

    // Leading-zero mask: zeros are suppressed from the top digit down until the first
    // non-zero code (minus and blank included). Digit 0 is never suppressed.
    always_comb begin
        supp    = '0;
        seen_nz = 1'b0;
        for (int k = int'(DIGITS) - 1; k >= 1; k--) begin
            if (active_code_q[4*k +: 4] != 4'd0) begin
                seen_nz = 1'b1;
            end
            supp[k] = bus.lz_en & ~seen_nz;
        end
    end

    assign cur_code = supp[slot_q] ? CODE_BLANK : active_code_q[slot_q*4 +: 4];
    assign cur_dp   = active_dp_q[slot_q];

    seg_decode u_decode (
        .code  (cur_code),
        .dp    (cur_dp),
        .light (dec_light)
    );

    always_comb begin
        ena_d   = '0;
        light_d = '0;
        if (lit) begin
            ena_d   = DIGITS'(1) << slot_q;
            light_d = dec_light;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q         <= '0;
            slot_q        <= '0;
            shadow_code_q <= '0;
            shadow_dp_q   <= '0;
            pending_q     <= 1'b0;
            active_code_q <= '0;
            active_dp_q   <= '0;
            ena_q         <= '0;
            light_q       <= '0;
            frame_done_q  <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            slot_q        <= slot_d;
            shadow_code_q <= shadow_code_d;
            shadow_dp_q   <= shadow_dp_d;
            pending_q     <= pending_d;
            active_code_q <= active_code_d;
            active_dp_q   <= active_dp_d;
            ena_q         <= ena_d;
            light_q       <= light_d;
            frame_done_q  <= boundary;
        end
    end

    assign bus.ena        = ena_q;
    assign bus.light      = light_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with DIGITS=4, DIV=8, BLANK=2.
// cyc counts rising edges since reset release; at a falling edge the registered
// outputs describe scan state cyc-1 (slot = (st/8)%4, cnt = st%8).
module tb_seg_scan_ctrl;
    logic clk;
    logic rst_n;
    int   cyc;
    int   checks;
    int   errors;

    seg_scan_ctrl_if #(.DIGITS(4)) bus ();

    seg_scan_ctrl #(
        .DIGITS (4),
        .DIV    (8),
        .BLANK  (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    function automatic logic [3:0] exp_ena(input int st);
        if ((st % 8) < 2) return 4'b0000;
        return 4'b0001 << ((st / 8) % 4);
    endfunction

    task automatic do_load(input logic [15:0] c, input logic [3:0] d);
        bus.code_in = c;
        bus.dp_in   = d;
        bus.load    = 1'b1;
        @(negedge clk);
        bus.load    = 1'b0;
    endtask

    task automatic wait_frame_done();
        bit ok;
        ok = (bus.frame_done === 1'b1);
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (bus.frame_done === 1'b1) ok = 1'b1;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL frame_done_wait: no pulse within 40 cycles (got 0, need 1)");
        end
    endtask

    // Called on the falling edge where frame_done is high; samples each slot at cnt=4.
    task automatic capture_frame(output logic [31:0] lights);
        lights = '0;
        for (int step = 1; step <= 32; step++) begin
            @(negedge clk);
            if ((step % 8) == 5) lights[((step - 5) / 8) * 8 +: 8] = bus.light;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #3 rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (bus.ena !== 4'b0 || bus.light !== 8'h00 || bus.frame_done !== 1'b0) begin
                errors++;
                $display("FAIL reset_outputs: ena=%b light=%h fd=%b, need 0/00/0",
                         bus.ena, bus.light, bus.frame_done);
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_scan();
        int st;
        int pulses;
        logic [3:0] e;
        logic [7:0] el;
        logic fd;
        pulses = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            st = cyc - 1;
            e  = exp_ena(st);
            fd = ((st % 32) == 31);
            el = (e != 0) ? 8'hFC : 8'h00;
            if (bus.frame_done === 1'b1) pulses++;
            checks++;
            if (bus.ena !== e) begin
                errors++;
                $display("FAIL scan_ena st=%0d: got %b need %b", st, bus.ena, e);
            end
            checks++;
            if (bus.frame_done !== fd) begin
                errors++;
                $display("FAIL scan_frame_done st=%0d: got %b need %b", st, bus.frame_done, fd);
            end
            checks++;
            if (bus.light !== el) begin
                errors++;
                $display("FAIL scan_light st=%0d: got %h need %h", st, bus.light, el);
            end
        end
        checks++;
        if (pulses != 2) begin
            errors++;
            $display("FAIL scan_pulse_count: got %0d need 2", pulses);
        end
    endtask

    task automatic check_frame(input string name, input logic [31:0] got,
                               input logic [31:0] exp);
        for (int s = 0; s < 4; s++) begin
            checks++;
            if (got[s*8 +: 8] !== exp[s*8 +: 8]) begin
                errors++;
                $display("FAIL %s slot%0d: got %h need %h", name, s, got[s*8 +: 8],
                         exp[s*8 +: 8]);
            end
        end
    endtask

    task automatic test_load();
        logic [31:0] got;
        wait_frame_done();
        repeat (10) @(negedge clk);
        do_load(16'h1234, 4'b0100);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.ena !== 4'b0) begin
                checks++;
                if (bus.light !== 8'hFC) begin
                    errors++;
                    $display("FAIL load_midframe_hold: got %h need fc", bus.light);
                end
            end
            if (bus.frame_done === 1'b1) break;
        end
        wait_frame_done();
        capture_frame(got);
        check_frame("load_1234", got, {8'h60, 8'hDB, 8'hF2, 8'h66});
    endtask

    task automatic test_lz();
        logic [31:0] got;
        bus.lz_en = 1'b1;
        repeat (5) @(negedge clk);
        do_load(16'h00A5, 4'b0000);
        wait_frame_done();
        capture_frame(got);
        check_frame("lz_on_00A5", got, {8'h00, 8'h00, 8'h02, 8'hB6});
        bus.lz_en = 1'b0;
        wait_frame_done();
        capture_frame(got);
        check_frame("lz_off_00A5", got, {8'hFC, 8'hFC, 8'h02, 8'hB6});
    endtask

    task automatic test_lz_zero();
        logic [31:0] got;
        bus.lz_en = 1'b1;
        repeat (5) @(negedge clk);
        do_load(16'h0000, 4'b0000);
        wait_frame_done();
        capture_frame(got);
        check_frame("lz_all_zero", got, {8'h00, 8'h00, 8'h00, 8'hFC});
        bus.lz_en = 1'b0;
    endtask

    task automatic test_last_load_wins();
        logic [31:0] got;
        repeat (6) @(negedge clk);
        do_load(16'h1111, 4'b0000);
        @(negedge clk);
        do_load(16'h2222, 4'b0000);
        for (int i = 0; i < 40; i++) begin
            if (bus.ena !== 4'b0) begin
                checks++;
                if (bus.light === 8'h60) begin
                    errors++;
                    $display("FAIL overwrite_no_1111: got %h need not 60", bus.light);
                end
            end
            if (bus.frame_done === 1'b1) break;
            @(negedge clk);
        end
        wait_frame_done();
        capture_frame(got);
        check_frame("overwrite_2222", got, {4{8'hDA}});
    endtask

    task automatic test_back_to_back();
        logic [31:0] got;
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            if ((cyc % 32) == 31) ok = 1'b1;
            else @(negedge clk);
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL boundary_wait: boundary not reached (got 0, need 1)");
        end
        do_load(16'h9999, 4'b0000);
        checks++;
        if (bus.frame_done !== 1'b1) begin
            errors++;
            $display("FAIL boundary_frame_done: got %b need 1", bus.frame_done);
        end
        capture_frame(got);
        check_frame("boundary_9999", got, {4{8'hF6}});
    endtask

    task automatic test_reset_mid();
        bit ok;
        logic [3:0] e;
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if ((cyc % 32) == 20) ok = 1'b1;
        end
        checks++;
        if (!ok || bus.ena !== 4'b0100 || bus.light !== 8'hF6) begin
            errors++;
            $display("FAIL midreset_pre: ena=%b light=%h, need 0100/f6", bus.ena, bus.light);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.ena !== 4'b0 || bus.light !== 8'h00 || bus.frame_done !== 1'b0) begin
            errors++;
            $display("FAIL midreset_async: ena=%b light=%h fd=%b, need 0/00/0",
                     bus.ena, bus.light, bus.frame_done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 1; n <= 3; n++) begin
            @(negedge clk);
            e = (n == 3) ? 4'b0001 : 4'b0000;
            checks++;
            if (bus.ena !== e) begin
                errors++;
                $display("FAIL midreset_restart_ena n=%0d: got %b need %b", n, bus.ena, e);
            end
        end
        checks++;
        if (bus.light !== 8'hFC) begin
            errors++;
            $display("FAIL midreset_restart_light: got %h need fc", bus.light);
        end
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        bus.load    = 1'b0;
        bus.code_in = '0;
        bus.dp_in   = '0;
        bus.lz_en   = 1'b0;
        test_reset();
        test_scan();
        test_load();
        test_lz();
        test_lz_zero();
        test_last_load_wins();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

- Parametrised multiplexed seven-segment display controller.
- Drives `DIGITS` common-enable digits from a packed BCD/code vector, one digit per time slot.
- Adds per-digit decimal points, leading-zero suppression, anti-ghosting blanking, and tear-free frame-synchronous updates.
- Sits between the CPU's display register and the board's segment/enable pins; successor to the fixed 4-digit scanner.

## Interface
Parameters:
- `DIGITS`, default 8: number of digits; legal range 1..16.
- `DIV`, default 100000: clk cycles per digit slot; must be ≥ 2.
- `BLANK`, default 1000: dead cycles at the start of each slot; must be < `DIV`.

Ports (one clock; reset is asynchronous and active-low):
- `clk`, in, 1: system clock.
- `rst_n`, in, 1: asynchronous active-low reset.
- `load`, in, 1: single-cycle strobe; captures `code_in` and `dp_in`.
- `code_in`, in, 4*DIGITS: nibble k is digit k; digit 0 is rightmost.
- `dp_in`, in, DIGITS: decimal point for each digit, 1 = lit.
- `lz_en`, in, 1: enables leading-zero suppression; sampled live.
- `ena`, out, DIGITS: one-hot digit enable, active-high.
- `light`, out, 8: segment pattern, bit7..bit1 = a..g, bit0 = dp, active-high.
- `frame_done`, out, 1: one-cycle pulse at the end of each full frame.

## Operation
- Code map:
  - 0–9 → decimal glyphs (0 = 1111_1100, 1 = 0110_0000, 8 = 1111_1110).
  - 4'hA → minus (0000_0010).
  - 4'hB–4'hF → blank (0000_000x).
  - The dp bit is ORed into bit0 for every code, including blank.
- Registers:
  - `cnt`: prescaler, 0..DIV-1.
  - `slot`: current digit, 0..DIGITS-1.
  - Shadow code/dp registers plus `pending` flag.
  - Active code/dp registers.
- `load` writes the shadow registers and sets `pending`. A repeated `load` overwrites the shadow; the last one wins.
- Frame boundary: `slot==DIGITS-1 && cnt==DIV-1`. At the boundary:
  - If `pending`, shadow is copied to active and `pending` is cleared.
  - If `load` is asserted on the boundary cycle, `code_in`/`dp_in` go straight to active and `pending` is cleared.
- Slot advance: when `cnt==DIV-1`, `cnt` goes to 0 and `slot` increments, wrapping from DIGITS-1 to 0.
- Blanking: while `cnt < BLANK`, `ena` is 0 and `light` is 0. Otherwise `ena = 1<<slot` and `light = decode(active code[slot], active dp[slot])`.
- Leading-zero suppression, when `lz_en=1`:
  - Scanning from digit DIGITS-1 downward, each code 0 is treated as blank until the first non-zero code is reached.
  - Digit 0 is never suppressed.
  - Any non-0 code, including minus and blank, ends suppression.
  - The dp of a suppressed digit still shows.

## Timing
- Reset (asynchronous): `cnt=0`, `slot=0`, `pending=0`, active and shadow registers all zero, `ena=0`, `light=0`, `frame_done=0`.
- `ena`, `light` and `frame_done` are registered. Each output reflects the state of the previous cycle (1-cycle latency).
- `frame_done` is high in the cycle after the boundary cycle.
- Frame period is exactly `DIGITS*DIV` cycles. Enable high time per slot is `DIV-BLANK` cycles.
- Loaded data first appears in the first lit cycle of slot 0 after the next boundary. It never changes mid-frame.
- If `rst_n` is asserted mid-frame, outputs drop to 0 immediately. After release, scanning restarts at slot 0 with `cnt=0`.
- `DIGITS=1`: `slot` stays 0, and every slot-end is also a frame boundary.
- Widths:
  - `cnt` is `$clog2(DIV)` bits.
  - `slot` is `max(1, $clog2(DIGITS))` bits.

## Structure
- Package `seg_pkg` holds:
  - Segment pattern constants (`SEG_0`..`SEG_9`, `SEG_MINUS`, `SEG_BLANK`).
  - Code constants `CODE_MINUS=4'hA` and `CODE_BLANK=4'hF`.
- Sub-module `seg_decode`: combinational 4-bit code + dp → 8-bit pattern, with a default blank arm so every code is covered.
- Top level holds the prescaler, slot counter, shadow/active registers, suppression mask and output registers.

## Test plan
All scenarios use `DIGITS=4`, `DIV=8`, `BLANK=2`.
1. Reset, then free-run 64 cycles:
   - `ena` sequence is 0001, 0010, 0100, 1000, repeating.
   - Each enable is high 6 cycles, preceded by 2 cycles at 0.
   - `frame_done` pulses every 32 cycles.
2. `load` `code_in=16'h1234`, `dp_in=4'b0100`:
   - Display is unchanged until the next frame.
   - Then slot 0 shows `light=0110_0110` (4).
   - Slot 2 shows `light=1101_1011` (2 with dp).
3. `code_in=16'h00A5` with `lz_en=1`:
   - Digits 3 and 2 are blank, digit 1 shows the minus pattern, digit 0 shows 5.
   - With `lz_en=0`, digits 3 and 2 show 0 (1111_1100).
4. `code_in=16'h0000` with `lz_en=1`: only digit 0 shows 0.
5. `load` 16'h1111 mid-frame, then 16'h2222 two cycles later: the next frame shows 2222 on every digit, and 1111 never appears.
6. `load` 16'h9999 on the exact boundary cycle: the following frame shows 9. Separately, assert `rst_n=0` in slot 2: `ena` and `light` are 0 immediately, and scanning resumes at slot 0.
